// File: rtl/fadd_far_pipe_n40.sv
// rtl/fadd_far_pipe_n40.sv - far-path mantissa add/sub with 3-stage elastic pipeline (align, add, normalize)
module fadd_far_pipe_n40 #(
    parameter int FRAC_WIDTH = 40,
    parameter int EXP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  eff_sub,
    input  logic                  far_sign,
    input  logic [EXP_WIDTH-1:0]  exp_l,
    input  logic [EXP_WIDTH-1:0]  exp_diff,
    input  logic [FRAC_WIDTH-1:0] elarge_op,
    input  logic [FRAC_WIDTH-1:0] esmall_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FRAC_WIDTH-1:0] far_result,
    output logic [EXP_WIDTH-1:0]  exp_far,
    output logic                  far_sign_o,
    output logic                  sticky
);
    localparam int SW = FRAC_WIDTH + 2;
    localparam int RW = FRAC_WIDTH + 3;
    localparam logic [EXP_WIDTH-1:0] SW_E  = EXP_WIDTH'(SW);
    localparam logic [EXP_WIDTH-1:0] ONE_E = EXP_WIDTH'(1);

    logic v1_q, v2_q, v3_q;
    logic rdy1, rdy2, rdy3;

    // Bubbles collapse: a stage is ready whenever it is empty or its successor moves.
    assign rdy3     = ~v3_q | out_ready;
    assign rdy2     = ~v2_q | rdy3;
    assign rdy1     = ~v1_q | rdy2;
    assign in_ready = rdy1;

    // S1: align the smaller operand, two guard bits kept below the LSB
    logic [SW-1:0] sm_ext;
    logic [SW-1:0] sm_shift_d;
    logic          sticky_a_d;

    always_comb begin
        sm_ext     = {esmall_op, 2'b00};
        sm_shift_d = '0;
        sticky_a_d = |esmall_op;
        if (exp_diff < SW_E) begin
            sm_shift_d = sm_ext >> exp_diff;
            sticky_a_d = |(sm_ext & ~({SW{1'b1}} << exp_diff));
        end
    end

    logic                  sub1_q, sign1_q, stk1_q;
    logic [EXP_WIDTH-1:0]  exp1_q;
    logic [FRAC_WIDTH-1:0] lop1_q;
    logic [SW-1:0]         sm1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            sub1_q  <= 1'b0;
            sign1_q <= 1'b0;
            stk1_q  <= 1'b0;
            exp1_q  <= '0;
            lop1_q  <= '0;
            sm1_q   <= '0;
        end else if (rdy1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                sub1_q  <= eff_sub;
                sign1_q <= far_sign;
                stk1_q  <= sticky_a_d;
                exp1_q  <= exp_l;
                lop1_q  <= elarge_op;
                sm1_q   <= sm_shift_d;
            end
        end
    end

    // S2: sticky from alignment rides along; it never borrows from the sum
    logic [RW-1:0] sum_d;

    always_comb begin
        sum_d = {1'b0, lop1_q, 2'b00} + {1'b0, sm1_q};
        if (sub1_q) begin
            sum_d = {1'b0, lop1_q, 2'b00} - {1'b0, sm1_q};
        end
    end

    logic                 sign2_q, stk2_q;
    logic [EXP_WIDTH-1:0] exp2_q;
    logic [RW-1:0]        r2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            sign2_q <= 1'b0;
            stk2_q  <= 1'b0;
            exp2_q  <= '0;
            r2_q    <= '0;
        end else if (rdy2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                sign2_q <= sign1_q;
                stk2_q  <= stk1_q;
                exp2_q  <= exp1_q;
                r2_q    <= sum_d;
            end
        end
    end

    // S3: at most one bit of left or right normalization is ever needed here
    logic [FRAC_WIDTH-1:0] res_d;
    logic [EXP_WIDTH-1:0]  exp_d;
    logic                  stk_d;

    always_comb begin
        res_d = r2_q[RW-3:1];
        exp_d = exp2_q - ONE_E;
        stk_d = stk2_q | r2_q[0];
        if (r2_q[RW-1]) begin
            res_d = r2_q[RW-1:3];
            exp_d = exp2_q + ONE_E;
            stk_d = stk2_q | (|r2_q[2:0]);
        end else if (r2_q[RW-2]) begin
            res_d = r2_q[RW-2:2];
            exp_d = exp2_q;
            stk_d = stk2_q | (|r2_q[1:0]);
        end
    end

    logic [FRAC_WIDTH-1:0] res3_q;
    logic [EXP_WIDTH-1:0]  exp3_q;
    logic                  sign3_q, stk3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q    <= 1'b0;
            res3_q  <= '0;
            exp3_q  <= '0;
            sign3_q <= 1'b0;
            stk3_q  <= 1'b0;
        end else if (rdy3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                res3_q  <= res_d;
                exp3_q  <= exp_d;
                sign3_q <= sign2_q;
                stk3_q  <= stk_d;
            end
        end
    end

    assign out_valid  = v3_q;
    assign far_result = res3_q;
    assign exp_far    = exp3_q;
    assign far_sign_o = sign3_q;
    assign sticky     = stk3_q;

endmodule

// File: tb/tb_fadd_far_pipe_n40.sv
// tb/tb_fadd_far_pipe_n40.sv - self-checking bench for fadd_far_pipe_n40
module tb_fadd_far_pipe_n40;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        eff_sub = 1'b0;
    logic        far_sign = 1'b0;
    logic [7:0]  exp_l = '0;
    logic [7:0]  exp_diff = '0;
    logic [39:0] elarge_op = '0;
    logic [39:0] esmall_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [39:0] far_result;
    logic [7:0]  exp_far;
    logic        far_sign_o;
    logic        sticky;

    int n_checks = 0;
    int n_pass = 0;

    fadd_far_pipe_n40 #(.FRAC_WIDTH(40), .EXP_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .eff_sub(eff_sub), .far_sign(far_sign), .exp_l(exp_l), .exp_diff(exp_diff),
        .elarge_op(elarge_op), .esmall_op(esmall_op), .out_valid(out_valid),
        .out_ready(out_ready), .far_result(far_result), .exp_far(exp_far),
        .far_sign_o(far_sign_o), .sticky(sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sub;
        logic        sign;
        logic [7:0]  e;
        logic [7:0]  d;
        logic [39:0] el;
        logic [39:0] es;
    } op_t;

    // Reference: {sign, mantissa, exponent, sticky} by plain integer arithmetic.
    function automatic logic [49:0] model(input op_t op);
        logic [63:0] ext, s, l, r;
        logic [39:0] m;
        logic [7:0]  e;
        logic        st;
        ext = 64'(op.es) * 4;
        if (op.d >= 8'd42) begin
            s  = 0;
            st = (op.es != 0);
        end else begin
            s  = ext >> op.d;
            st = ((s << op.d) != ext);
        end
        l = 64'(op.el) * 4;
        r = op.sub ? (l - s) : (l + s);
        r = r % (64'd1 << 43);
        if (r >= (64'd1 << 42)) begin
            m = 40'(r / 8); e = op.e + 8'd1; st = st | ((r % 8) != 0);
        end else if (r >= (64'd1 << 41)) begin
            m = 40'(r / 4); e = op.e;        st = st | ((r % 4) != 0);
        end else begin
            m = 40'(r / 2); e = op.e - 8'd1; st = st | ((r % 2) != 0);
        end
        return {op.sign, m, e, st};
    endfunction

    function automatic op_t rand_op();
        op_t op;
        op.sub  = 1'($urandom);
        op.sign = 1'($urandom);
        op.e    = 8'($urandom);
        op.d    = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 45));
        op.el   = {1'b1, 32'($urandom), 7'($urandom)};
        op.es   = {32'($urandom), 8'($urandom)};
        if ($urandom_range(0, 3) == 0) op.es = 40'($urandom_range(0, 15));
        return op;
    endfunction

    task automatic drive_op(input op_t op);
        eff_sub = op.sub; far_sign = op.sign; exp_l = op.e; exp_diff = op.d;
        elarge_op = op.el; esmall_op = op.es;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({out_valid, far_result, exp_far, far_sign_o, sticky} !== 51'd0)
            $display("FAIL reset_outputs: got %h want 0", {out_valid, far_result, exp_far, far_sign_o, sticky});
        else n_pass++;
        @(negedge clk); rst_n = 1'b1; #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic run_directed(input string name, input op_t op,
                                input logic [39:0] x_m, input logic [7:0] x_e, input logic x_st);
        int lat;
        out_ready = 1'b1;
        @(negedge clk); drive_op(op); in_valid = 1'b1; #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL %s_accept: in_ready %b want 1", name, in_ready);
        else n_pass++;
        @(negedge clk); in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
        n_checks++;
        if (lat != 3) $display("FAIL %s_latency: got %0d want 3", name, lat);
        else n_pass++;
        n_checks++;
        if ({far_result, exp_far, sticky, far_sign_o} !== {x_m, x_e, x_st, op.sign})
            $display("FAIL %s_result: got m=%h e=%h st=%b s=%b want m=%h e=%h st=%b s=%b",
                     name, far_result, exp_far, sticky, far_sign_o, x_m, x_e, x_st, op.sign);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        run_directed("add",      '{0, 0, 8'h10, 8'd2,  40'h80_0000_0000, 40'h80_0000_0000}, 40'hA0_0000_0000, 8'h10, 1'b0);
        run_directed("carry",    '{0, 1, 8'hFF, 8'd2,  40'hFF_FFFF_FFFF, 40'h80_0000_0000}, 40'h8F_FFFF_FFFF, 8'h00, 1'b1);
        run_directed("sub",      '{1, 0, 8'h20, 8'd2,  40'h80_0000_0000, 40'hFF_FFFF_FFFF}, 40'h80_0000_0000, 8'h1F, 1'b1);
        run_directed("bigshift", '{0, 1, 8'h40, 8'h50, 40'hC0_0000_0000, 40'h1},            40'hC0_0000_0000, 8'h40, 1'b1);
    endtask

    task automatic test_backpressure();
        op_t ops[5];
        logic [49:0] xp[5];
        logic [49:0] snap;
        int idx, j;
        for (int i = 0; i < 5; i++) begin ops[i] = rand_op(); xp[i] = model(ops[i]); end
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            in_valid = (idx < 5);
            if (idx < 5) drive_op(ops[idx]);
            #1;
            if (in_valid && in_ready) idx++;
        end
        n_checks++;
        if (idx != 3) $display("FAIL bp_accepted: got %0d want 3", idx);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready);
        else n_pass++;
        snap = {far_sign_o, far_result, exp_far, sticky};
        n_checks++;
        if (snap !== xp[0] || out_valid !== 1'b1) $display("FAIL bp_head: got %h v=%b want %h v=1", snap, out_valid, xp[0]);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({far_sign_o, far_result, exp_far, sticky} !== snap || out_valid !== 1'b1)
                $display("FAIL bp_frozen: got %h v=%b want %h v=1", {far_sign_o, far_result, exp_far, sticky}, out_valid, snap);
            else n_pass++;
        end
        j = 0;
        for (int c = 0; c < 10 && j < 5; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (idx < 5);
            if (idx < 5) drive_op(ops[idx]);
            #1;
            n_checks++;
            if (out_valid !== 1'b1) $display("FAIL bp_drain_gap: out_valid %b at result %0d want 1", out_valid, j);
            else if ({far_sign_o, far_result, exp_far, sticky} !== xp[j])
                $display("FAIL bp_drain_data: result %0d got %h want %h", j, {far_sign_o, far_result, exp_far, sticky}, xp[j]);
            else n_pass++;
            if (out_valid) j++;
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (j != 5) $display("FAIL bp_count: got %0d want 5", j);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [49:0] q[$];
        logic [49:0] got, want;
        op_t op;
        int budget;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            op = rand_op();
            drive_op(op);
            #1;
            if (out_valid && out_ready) begin
                got = {far_sign_o, far_result, exp_far, sticky};
                want = (q.size() > 0) ? q.pop_front() : 50'h0;
                n_checks++;
                if (got !== want) $display("FAIL rand_result: cycle %0d got %h want %h", c, got, want);
                else n_pass++;
            end
            if (in_valid && in_ready) q.push_back(model(op));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            #1;
            if (out_valid) begin
                got = {far_sign_o, far_result, exp_far, sticky};
                want = q.pop_front();
                n_checks++;
                if (got !== want) $display("FAIL rand_drain: got %h want %h", got, want);
                else n_pass++;
            end
            @(negedge clk);
            budget++;
        end
        n_checks++;
        if (q.size() != 0) $display("FAIL rand_leftover: %0d results missing want 0", q.size());
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        op_t op;
        int stale;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op = '{0, 1, 8'h33, 8'd1, 40'hF0_1234_5678, 40'hAB_CDEF_0123};
            op.e = op.e + 8'(i);
            drive_op(op);
            in_valid = 1'b1;
        end
        @(negedge clk); in_valid = 1'b0;
        rst_n = 1'b0; #1;
        n_checks++;
        if ({out_valid, far_result, exp_far, far_sign_o, sticky} !== 51'd0)
            $display("FAIL midreset_outputs: got %h want 0", {out_valid, far_result, exp_far, far_sign_o, sticky});
        else n_pass++;
        @(negedge clk); rst_n = 1'b1; #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL midreset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        stale = 0;
        for (int c = 0; c < 6; c++) begin @(negedge clk); if (out_valid) stale++; end
        n_checks++;
        if (stale != 0) $display("FAIL midreset_stale: %0d stale results want 0", stale);
        else n_pass++;
        run_directed("post_reset", '{0, 0, 8'h10, 8'd2, 40'h80_0000_0000, 40'h80_0000_0000}, 40'hA0_0000_0000, 8'h10, 1'b0);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fadd_far_pipe_n40.md
FADD_FAR_PIPE_N40 -- requirements
Module: fadd_far_pipe_N40

Interface
REQ-001 SHALL have parameter FRAC_WIDTH, default 40, mantissa width incl. hidden bit; only 40 is required to be supported.
REQ-002 SHALL have parameter EXP_WIDTH, default 8, exponent width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers an operation.
REQ-006 SHALL have port in_ready  output  1  block accepts the offered operation this cycle.
REQ-007 SHALL have port eff_sub  input  1  1 = effective subtraction, 0 = effective addition.
REQ-008 SHALL have port far_sign  input  1  sign of the larger-exponent operand.
REQ-009 SHALL have port exp_l  input  EXP_WIDTH  exponent of the larger operand.
REQ-010 SHALL have port exp_diff  input  EXP_WIDTH  exponent difference, unsigned.
REQ-011 SHALL have port elarge_op  input  FRAC_WIDTH  larger-exponent mantissa, normalized (bit 39 = 1).
REQ-012 SHALL have port esmall_op  input  FRAC_WIDTH  smaller-exponent mantissa.
REQ-013 SHALL have port out_valid  output  1  result presented.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-015 SHALL have port far_result  output  FRAC_WIDTH  normalized, truncated mantissa.
REQ-016 SHALL have port exp_far  output  EXP_WIDTH  result exponent.
REQ-017 SHALL have port far_sign_o  output  1  result sign (far_sign passed through).
REQ-018 SHALL have port sticky  output  1  OR of all discarded bits.

Function
REQ-019 SHALL transfer on a port when valid and ready are both 1 on the same rising edge.
REQ-020 SHALL be 3 registered stages (S1 align, S2 add/sub, S3 normalize); latency from input transfer to out_valid = 3 cycles with no stall.
REQ-021 SHALL compute per-stage ready: rdy3 = ~v3 | out_ready; rdy2 = ~v2 | rdy3; rdy1 = ~v1 | rdy2; in_ready = rdy1 (bubbles collapse, combinational chain).
REQ-022 SHALL hold each stage's data and valid unchanged while that stage is valid and its downstream is not ready.
REQ-023 SHALL keep results in input order; throughput one operation per cycle when out_ready = 1.
REQ-024 S1: S = ({esmall_op,2'b00} >> exp_diff), 42 bits; sticky_a = OR of bits shifted out; if exp_diff >= 42, S = 0 and sticky_a = |esmall_op.
REQ-025 S2: L = {1'b0,elarge_op,2'b00}, 43 bits; R = L + {1'b0,S} if eff_sub = 0, else R = L - {1'b0,S}, modulo 2^43; sticky_a carried, not subtracted.
REQ-026 S3: if R[42]: far_result = R[42:3], exp_far = exp_l+1, sticky = sticky_a|R[2]|R[1]|R[0].
REQ-027 S3: else if R[41]: far_result = R[41:2], exp_far = exp_l, sticky = sticky_a|R[1]|R[0].
REQ-028 S3: else: far_result = R[40:1], exp_far = exp_l-1, sticky = sticky_a|R[0].
REQ-029 SHALL compute exponent arithmetic modulo 2^EXP_WIDTH (wrap; no saturation, no flags).
REQ-030 SHALL hold all outputs stable while out_valid = 1 and out_ready = 0.
REQ-031 SHALL not check input legality (eff_sub with exp_diff < 2 and unnormalized elarge_op give undefined but deterministic results).

Reset
REQ-032 SHALL, while rst_n = 0, immediately clear all stage valids; out_valid = 0, far_result = 0, exp_far = 0, far_sign_o = 0, sticky = 0.
REQ-033 SHALL discard in-flight operations on reset mid-operation; in_ready = 1 on the first cycle after release.

Verification
REQ-034 Add: elarge=0x80_0000_0000, esmall=0x80_0000_0000, exp_diff=2, exp_l=0x10 -> 3 cycles later far_result=0xA0_0000_0000, exp_far=0x10, sticky=0.
REQ-035 Carry+wrap: add, elarge=0xFF_FFFF_FFFF, esmall=0x80_0000_0000, exp_diff=2, exp_l=0xFF -> far_result=0x8F_FFFF_FFFF, exp_far=0x00, sticky=1.
REQ-036 Sub: elarge=0x80_0000_0000, esmall=0xFF_FFFF_FFFF, exp_diff=2, exp_l=0x20 -> far_result=0x80_0000_0000, exp_far=0x1F, sticky=1.
REQ-037 Huge shift: add, elarge=0xC0_0000_0000, esmall=0x1, exp_diff=0x50, exp_l=0x40 -> far_result=0xC0_0000_0000, exp_far=0x40, sticky=1.
REQ-038 Backpressure: out_ready=0, offer 5 ops -> exactly 3 accepted, in_ready=0 afterwards, outputs frozen; out_ready=1 -> all 5 emerge in order, one per cycle.
REQ-039 Reset: assert rst_n=0 with 3 ops in flight -> out_valid=0 at once; after release, no stale result appears and a new op returns after 3 cycles.
